bcd_adder_2digit: RTL and testbench

- Registered packed-BCD adder: adds two NUM_DIGITS-digit BCD operands plus a carry-in, and produces a BCD sum plus a decimal carry-out.
- Used as the decimal arithmetic stage in the datapath, with one clock of latency and a simple valid qualifier.
- Flags any non-BCD input digit so upstream logic can detect corrupt operands.

---
 rtl/bcd_pkg.sv | 10 +
 rtl/bcd_digit_adder.sv | 33 +++
 rtl/bcd_adder_2digit.sv | 57 +++++
 tb/tb_bcd_adder_2digit.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD types and constants for the decimal arithmetic datapath.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned BCD_DIGIT_W    = 4;
  localparam int unsigned BCD_MAX_DIGIT  = 9;
  localparam int unsigned BCD_CORRECTION = 6;

endpackage : bcd_pkg

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit BCD adder with decimal carry and invalid-digit detect.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  bcd_digit_t a_d,
  input  bcd_digit_t b_d,
  input  logic       c_in,
  output bcd_digit_t sum_d,
  output logic       c_out,
  output logic       invalid
);

  localparam int unsigned TW = BCD_DIGIT_W + 1;

  logic [TW-1:0] t;

  assign t = TW'(a_d) + TW'(b_d) + TW'(c_in);

  // Sums above 9 skip the six unused codes; only the low nibble is kept.
  always_comb begin
    c_out   = 1'b0;
    sum_d   = t[BCD_DIGIT_W-1:0];
    invalid = 1'b0;
    if (t > TW'(BCD_MAX_DIGIT)) begin
      c_out = 1'b1;
      sum_d = BCD_DIGIT_W'(t + TW'(BCD_CORRECTION));
    end
    if ((a_d > BCD_DIGIT_W'(BCD_MAX_DIGIT)) || (b_d > BCD_DIGIT_W'(BCD_MAX_DIGIT))) begin
      invalid = 1'b1;
    end
  end

endmodule : bcd_digit_adder

// File: rtl/bcd_adder_2digit.sv
// Registered packed-BCD adder: ripple of per-digit adders, one cycle latency,
// with a sticky-per-result flag for any non-BCD input digit.
module bcd_adder_2digit
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] a,
  input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] b,
  input  logic                          cin,
  output logic [BCD_DIGIT_W*NUM_DIGITS-1:0] s,
  output logic                          cout,
  output logic                          out_valid,
  output logic                          err
);

  localparam int unsigned W = BCD_DIGIT_W * NUM_DIGITS;

  logic [NUM_DIGITS:0]   carry_c;
  logic [W-1:0]          sum_c;
  logic [NUM_DIGITS-1:0] invalid_c;

  assign carry_c[0] = cin;

  // Carry ripples combinationally across all digits within the cycle.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_adder u_digit (
      .a_d    (a[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
      .b_d    (b[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
      .c_in   (carry_c[i]),
      .sum_d  (sum_c[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
      .c_out  (carry_c[i+1]),
      .invalid(invalid_c[i])
    );
  end

  // Result registers hold their value when no new operation is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      s         <= '0;
      cout      <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s    <= sum_c;
        cout <= carry_c[NUM_DIGITS];
        err  <= |invalid_c;
      end
    end
  end

endmodule : bcd_adder_2digit

// File: tb/tb_bcd_adder_2digit.sv
// Scoreboard bench for bcd_adder_2digit: driver queues expected results, monitor checks each cycle.
module tb_bcd_adder_2digit;

  localparam int unsigned W = 8;

  typedef enum logic [1:0] {K_VALID, K_RESET} kind_e;

  typedef struct {
    int         due;
    kind_e      kind;
    logic [W-1:0] s;
    logic       cout;
    logic       err;
    string      name;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a, b;
  logic         cin;
  logic [W-1:0] s;
  logic         cout;
  logic         out_valid;
  logic         err;

  int           cyc = 0;
  int           n_vec = 0;
  int           n_bad = 0;
  exp_t         sb[$];
  logic [W-1:0] hold_s = '0;
  logic         hold_cout = 1'b0;
  logic         hold_err = 1'b0;

  bcd_adder_2digit #(.NUM_DIGITS(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .s        (s),
    .cout     (cout),
    .out_valid(out_valid),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic ev, logic [W-1:0] es, logic ec, logic ee);
    n_vec++;
    if (out_valid !== ev || s !== es || cout !== ec || err !== ee) begin
      n_bad++;
      $display("FAIL %s: got valid=%b s=%h cout=%b err=%b, expected valid=%b s=%h cout=%b err=%b",
               name, out_valid, s, cout, err, ev, es, ec, ee);
    end
  endfunction

  // Monitor: retire the entry due this cycle, otherwise expect idle with held outputs.
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        if (e.kind == K_VALID) begin
          check(e.name, 1'b1, e.s, e.cout, e.err);
          hold_s = e.s; hold_cout = e.cout; hold_err = e.err;
        end else begin
          check(e.name, 1'b0, '0, 1'b0, 1'b0);
          hold_s = '0; hold_cout = 1'b0; hold_err = 1'b0;
        end
      end else begin
        check("idle_hold", 1'b0, hold_s, hold_cout, hold_err);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(string name, logic [W-1:0] ta, logic [W-1:0] tb, logic tc,
                       logic [W-1:0] es, logic ec, logic ee);
    exp_t e;
    rst = 1'b0; in_valid = 1'b1; a = ta; b = tb; cin = tc;
    e.due = cyc + 1; e.kind = K_VALID; e.s = es; e.cout = ec; e.err = ee; e.name = name;
    sb.push_back(e);
    step();
  endtask

  task automatic reset_cycle(string name, logic iv, logic [W-1:0] ta, logic [W-1:0] tb);
    exp_t e;
    rst = 1'b1; in_valid = iv; a = ta; b = tb; cin = 1'b0;
    e.due = cyc + 1; e.kind = K_RESET; e.s = '0; e.cout = 1'b0; e.err = 1'b0; e.name = name;
    sb.push_back(e);
    step();
  endtask

  task automatic idle();
    rst = 1'b0; in_valid = 1'b0; a = 8'hEE; b = 8'hEE; cin = 1'b1;
    step();
  endtask

  initial begin
    int budget;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    reset_cycle("reset0", 1'b0, 8'h00, 8'h00);
    reset_cycle("reset1", 1'b0, 8'h00, 8'h00);
    idle();

    issue("01+01",       8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
    idle();
    issue("09+09+1",     8'h09, 8'h09, 1'b1, 8'h19, 1'b0, 1'b0);
    idle();
    issue("b2b_10+01",   8'h10, 8'h01, 1'b0, 8'h11, 1'b0, 1'b0);
    issue("b2b_41+11",   8'h41, 8'h11, 1'b0, 8'h52, 1'b0, 1'b0);
    issue("99+99+1",     8'h99, 8'h99, 1'b1, 8'h99, 1'b1, 1'b0);
    idle();
    idle();
    issue("0A+00",       8'h0A, 8'h00, 1'b0, 8'h10, 1'b0, 1'b1);
    issue("95+04+1",     8'h95, 8'h04, 1'b1, 8'h00, 1'b1, 1'b0);
    issue("09+00+1",     8'h09, 8'h00, 1'b1, 8'h10, 1'b0, 1'b0);
    issue("00+00+0",     8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    issue("0F+0F",       8'h0F, 8'h0F, 1'b0, 8'h14, 1'b0, 1'b1);
    issue("A0+00",       8'hA0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    issue("50+50",       8'h50, 8'h50, 1'b0, 8'h00, 1'b1, 1'b0);
    idle();
    issue("pre_rst_37+25", 8'h37, 8'h25, 1'b0, 8'h62, 1'b0, 1'b0);
    reset_cycle("rst_with_valid", 1'b1, 8'h55, 8'h44);
    idle();
    issue("resume_12+34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    issue("resume_58+67+1", 8'h58, 8'h67, 1'b1, 8'h26, 1'b1, 1'b0);
    idle();
    idle();

    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      idle();
      budget--;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d results still pending, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_bcd_adder_2digit
